// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID instruction queue.
// master = fetch + decode controls (testbench or pipeline), slave = the queue.
interface if_id_queue_if #(
    parameter int DATA_W = 32
) ();
    logic              inst_valid_F;
    logic              inst_ready_F;
    logic [DATA_W-1:0] inst_F;
    logic [DATA_W-1:0] pc_F;
    logic              fetch_err_F;
    logic              StallD;
    logic              FlushD;
    logic              validD;
    logic [DATA_W-1:0] InstrD;
    logic [DATA_W-1:0] PCPlus4D;
    logic [DATA_W-1:0] PCD;
    logic [15:0]       ImD;
    logic              FetchErrD;

    modport master (
        output inst_valid_F, inst_F, pc_F, fetch_err_F, StallD, FlushD,
        input  inst_ready_F, validD, InstrD, PCPlus4D, PCD, ImD, FetchErrD
    );

    modport slave (
        input  inst_valid_F, inst_F, pc_F, fetch_err_F, StallD, FlushD,
        output inst_ready_F, validD, InstrD, PCPlus4D, PCD, ImD, FetchErrD
    );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction buffer: small first-word-fall-through FIFO of {err, pc, inst}
// between the AXI fetch unit and decode, with stall and flush support.
module if_id_queue #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic          clock,
    input  logic          reset,
    if_id_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               inst_ready_q, inst_ready_d;

    logic               push;
    logic               pop;
    logic               not_empty;
    entry_t             head;
    entry_t             wr_entry;

    assign not_empty = (count_q != '0);
    assign push      = bus.inst_valid_F && inst_ready_q && !bus.FlushD;
    assign pop       = not_empty && !bus.StallD && !bus.FlushD;

    always_comb begin
        wr_entry.err  = bus.fetch_err_F;
        wr_entry.pc   = bus.pc_F;
        wr_entry.inst = bus.inst_F;
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_entry;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.FlushD) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Ready looks at next-cycle occupancy, so a pop from full only reopens the
    // door one cycle later and there is no comb path from StallD/inst_valid_F.
    always_comb begin
        inst_ready_d = (count_d < CNT_W'(DEPTH));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            inst_ready_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            inst_ready_q <= inst_ready_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Empty queue presents all-zero fields, i.e. a NOP to decode.
    always_comb begin
        head = mem_q[rd_ptr_q];
        bus.inst_ready_F = inst_ready_q;
        bus.validD       = not_empty;
        bus.InstrD       = '0;
        bus.PCD          = '0;
        bus.PCPlus4D     = '0;
        bus.ImD          = '0;
        bus.FetchErrD    = 1'b0;
        if (not_empty) begin
            bus.InstrD    = head.inst;
            bus.PCD       = head.pc;
            bus.PCPlus4D  = head.pc + DATA_W'(4);
            bus.ImD       = head.inst[15:0];
            bus.FetchErrD = head.err;
        end
    end
endmodule
